traffic_light_seq: RTL

- Timed two-direction traffic-light sequencer that owns its own phase timing.
- It is the successor to the purely combinational light decode.
- Contains an internal tick prescaler, a per-phase tick timer and a Moore FSM.
- Adds three features the combinational decode lacks: all-red clearance, pedestrian-request green truncation, and a night flash mode.
- Sits at the top of the intersection design and drives the lamp outputs directly.

---
 rtl/traffic_pkg.sv | 71 +++++++
 rtl/tick_prescaler.sv | 46 ++++
 rtl/traffic_light_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the timed traffic-light sequencer: state encoding,
// lamp-vector bit positions and the Moore lamp decode.
package traffic_pkg;

    // Sequencer states; the numeric codes are visible on the PHASE debug port.
    typedef enum logic [2:0] {
        S_G1    = 3'd0,
        S_Y1    = 3'd1,
        S_AR1   = 3'd2,
        S_G2    = 3'd3,
        S_Y2    = 3'd4,
        S_AR2   = 3'd5,
        S_FLASH = 3'd6
    } state_e;

    // Bit positions inside a per-direction lamp vector.
    localparam int unsigned LAMP_R = 0;
    localparam int unsigned LAMP_Y = 1;
    localparam int unsigned LAMP_G = 2;

    // Lamp vectors for both directions.
    typedef struct packed {
        logic [2:0] d1;
        logic [2:0] d2;
    } lamps_t;

    // Both directions red: the safe fallback and reset pattern.
    localparam lamps_t LAMPS_ALL_RED = '{d1: 3'b001, d2: 3'b001};

    // Moore decode of a state into lamp vectors. The unused code falls back to
    // all-red so a corrupted state can never show conflicting greens.
    function automatic lamps_t lamp_decode(input state_e st, input logic flash_ph);
        lamps_t l;
        l = '0;
        case (st)
            S_G1: begin
                l.d1[LAMP_G] = 1'b1;
                l.d2[LAMP_R] = 1'b1;
            end
            S_Y1: begin
                l.d1[LAMP_Y] = 1'b1;
                l.d2[LAMP_R] = 1'b1;
            end
            S_AR1, S_AR2: begin
                l = LAMPS_ALL_RED;
            end
            S_G2: begin
                l.d1[LAMP_R] = 1'b1;
                l.d2[LAMP_G] = 1'b1;
            end
            S_Y2: begin
                l.d1[LAMP_R] = 1'b1;
                l.d2[LAMP_Y] = 1'b1;
            end
            S_FLASH: begin
                l.d1[LAMP_Y] = flash_ph;
                l.d2[LAMP_R] = flash_ph;
            end
            default: begin
                l = LAMPS_ALL_RED;
            end
        endcase
        return l;
    endfunction

    // True for the two yellow states, whose entry clears the pedestrian latch.
    function automatic logic is_yellow(input state_e st);
        return (st == S_Y1) || (st == S_Y2);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle enable strobe every
// CLK_PER_TICK enabled cycles. Freezes while EN is low.
module tick_prescaler #(
    parameter int unsigned CLK_PER_TICK = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_TICK - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wrap_s;

    // Next count: advance while enabled, wrap after the last count.
    always_comb begin
        count_d = count_q;
        wrap_s  = (count_q == CNT_LAST);
        if (EN) begin
            if (wrap_s) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Strobe is suppressed during reset so CLK_PER_TICK=1 cannot tick in reset.
    assign TICK = wrap_s & EN & ~rst;

endmodule

// File: rtl/traffic_light_seq.sv
// Timed two-direction traffic-light sequencer with all-red clearance,
// pedestrian green truncation and night flash mode. Lamps are registered.
module traffic_light_seq
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK    = 50_000_000,
    parameter int unsigned GREEN_TICKS     = 20,
    parameter int unsigned MIN_GREEN_TICKS = 5,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned ALLRED_TICKS    = 1,
    parameter int unsigned TIMER_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic       PED_REQ,
    input  logic       FLASH_MODE,
    output logic       G1,
    output logic       Y1,
    output logic       R1,
    output logic       G2,
    output logic       Y2,
    output logic       R2,
    output logic [2:0] PHASE,
    output logic       TICK
);

    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] MIN_LAST    = TIMER_W'(MIN_GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_TICKS - 1);

    state_e             state_q;
    state_e             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               ped_q;
    logic               ped_d;
    logic               flash_ph_q;
    logic               flash_ph_d;
    lamps_t             lamps_q;
    lamps_t             lamps_d;

    logic               tick_s;
    logic               ped_pend_s;
    logic               green_done_s;
    logic               yellow_done_s;
    logic               allred_done_s;

    tick_prescaler #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .EN  (EN),
        .TICK(tick_s)
    );

    // Phase-end conditions; a live request counts even before it is latched.
    always_comb begin
        ped_pend_s    = ped_q | PED_REQ;
        green_done_s  = (timer_q == GREEN_LAST) || (ped_pend_s && (timer_q >= MIN_LAST));
        yellow_done_s = (timer_q == YELLOW_LAST);
        allred_done_s = (timer_q == ALLRED_LAST);
    end

    // Next-state logic; the state only moves on a tick.
    always_comb begin
        state_d = state_q;
        if (tick_s) begin
            case (state_q)
                S_G1: begin
                    if (green_done_s) state_d = S_Y1;
                    else              state_d = S_G1;
                end
                S_Y1: begin
                    if (yellow_done_s) state_d = S_AR1;
                    else               state_d = S_Y1;
                end
                S_AR1: begin
                    if (allred_done_s) state_d = FLASH_MODE ? S_FLASH : S_G2;
                    else               state_d = S_AR1;
                end
                S_G2: begin
                    if (green_done_s) state_d = S_Y2;
                    else              state_d = S_G2;
                end
                S_Y2: begin
                    if (yellow_done_s) state_d = S_AR2;
                    else               state_d = S_Y2;
                end
                S_AR2: begin
                    if (allred_done_s) state_d = FLASH_MODE ? S_FLASH : S_G1;
                    else               state_d = S_AR2;
                end
                S_FLASH: begin
                    if (!FLASH_MODE) state_d = S_AR2;
                    else             state_d = S_FLASH;
                end
                default: begin
                    state_d = S_AR2;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Phase timer, pedestrian latch, flash phase and the registered lamp decode.
    always_comb begin
        timer_d    = timer_q;
        ped_d      = ped_q;
        flash_ph_d = flash_ph_q;

        if (tick_s) begin
            if (state_d != state_q) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end else begin
            timer_d = timer_q;
        end

        // Clear on yellow entry first so a coincident request re-sets it.
        if (is_yellow(state_d) && (state_d != state_q)) begin
            ped_d = 1'b0;
        end else begin
            ped_d = ped_q;
        end
        if (PED_REQ) begin
            ped_d = 1'b1;
        end else begin
            ped_d = ped_d;
        end

        // Flash phase runs only inside FLASH and restarts dark on every entry.
        if (state_d != S_FLASH) begin
            flash_ph_d = 1'b0;
        end else if (tick_s && (state_q == S_FLASH)) begin
            flash_ph_d = ~flash_ph_q;
        end else begin
            flash_ph_d = flash_ph_q;
        end

        lamps_d = lamp_decode(state_d, flash_ph_d);
    end

    // State, timer, latch and lamp registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_AR2;
            timer_q    <= '0;
            ped_q      <= 1'b0;
            flash_ph_q <= 1'b0;
            lamps_q    <= LAMPS_ALL_RED;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_q      <= ped_d;
            flash_ph_q <= flash_ph_d;
            lamps_q    <= lamps_d;
        end
    end

    assign G1    = lamps_q.d1[LAMP_G];
    assign Y1    = lamps_q.d1[LAMP_Y];
    assign R1    = lamps_q.d1[LAMP_R];
    assign G2    = lamps_q.d2[LAMP_G];
    assign Y2    = lamps_q.d2[LAMP_Y];
    assign R2    = lamps_q.d2[LAMP_R];
    assign PHASE = state_q;
    assign TICK  = tick_s;

endmodule
